// File: rtl/imem_loader_pkg.sv
// Shared types and default geometry for the boot-time IMEM loader.
package imem_loader_pkg;

  localparam int unsigned DEPTH_DEF  = 64;
  localparam int unsigned ADDR_W_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: framed little-endian byte stream -> sequential IMEM word writes, holds the core in reset until done.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk_w,
  input  logic              i_rst_w,
  input  logic              i_start_w,
  input  logic [7:0]        i_byte_w,
  input  logic              i_byte_valid_w,
  output logic              o_byte_ready_w,
  output logic              o_we_w,
  output logic [ADDR_W-1:0] o_waddr_w,
  output logic [31:0]       o_wdata_w,
  output logic              o_cpu_rst_n_w,
  output logic              o_done_w,
  output logic              o_err_w
);

  // One extra bit so the remaining-word count can hold DEPTH itself.
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          lane_q, lane_d;
  logic [CNT_W-1:0]    left_q, left_d;
  logic [31:0]         word_q, word_d;
  logic                byte_ready_q, byte_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                take_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  assign take_c = i_byte_valid_w && byte_ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    left_d  = left_q;
    word_d  = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    case (state_q)
      IDLE, DONE, ERR: begin
        if (i_start_w) begin
          state_d = COUNT;
          addr_d  = '0;
          lane_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      COUNT: begin
        if (take_c) begin
          if ((i_byte_w != 8'd0) && (32'(i_byte_w) <= DEPTH)) begin
            state_d = DATA;
            left_d  = CNT_W'(i_byte_w);
          end else begin
            state_d = ERR;
          end
        end
      end
      DATA: begin
        if (take_c) begin
          word_d[8*lane_q +: 8] = i_byte_w;
          lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + i_byte_w;
`endif
          if (lane_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        left_d = left_q - CNT_W'(1);
        if (left_q == CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (take_c) state_d = (i_byte_w == sum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    byte_ready_d = (state_d == COUNT) || (state_d == DATA) || (state_d == CHECK);
    we_d         = (state_d == WRITE);
    waddr_d      = we_d ? addr_d : waddr_q;
    wdata_d      = we_d ? word_d : wdata_q;
    cpu_rst_n_d  = (state_d == DONE);
    done_d       = (state_d == DONE);
    err_d        = (state_d == ERR);
  end

  always_ff @(posedge i_clk_w or negedge i_rst_w) begin
    if (!i_rst_w) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lane_q       <= '0;
      left_q       <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cpu_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      left_q       <= left_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign o_byte_ready_w = byte_ready_q;
  assign o_we_w         = we_q;
  assign o_waddr_w      = waddr_q;
  assign o_wdata_w      = wdata_q;
  assign o_cpu_rst_n_w  = cpu_rst_n_q;
  assign o_done_w       = done_q;
  assign o_err_w        = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: receives a framed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them sequentially into IMEM starting at word address 0. It holds the MIPS core in reset until a load completes, then releases it. It sits in TOP between an external byte source (UART receiver or testbench) and the IMEM write port.

## Interface
- DEPTH, 64, IMEM depth in words; legal word counts are 1..DEPTH
- ADDR_W, 6, word-address width (log2 DEPTH)
- i_clk_w  in  1  clock
- i_rst_w  in  1  reset, asynchronous, active-low
- i_start_w  in  1  begin a load; honoured only in IDLE, DONE or ERR
- i_byte_w  in  8  stream byte
- i_byte_valid_w  in  1  source has a byte on i_byte_w
- o_byte_ready_w  out  1  loader accepts the byte this cycle
- o_we_w  out  1  IMEM write strobe, one cycle per word
- o_waddr_w  out  ADDR_W  IMEM word address
- o_wdata_w  out  32  IMEM write data
- o_cpu_rst_n_w  out  1  active-low reset to MIPS core; high only in DONE
- o_done_w  out  1  load completed successfully
- o_err_w  out  1  load aborted: bad count or checksum mismatch

## Operation
- Frame: count byte N, then 4N payload bytes (each word LSB first), then one checksum byte (macro-dependent).
- A byte transfers when i_byte_valid_w && o_byte_ready_w at a rising edge.
- States: IDLE -> COUNT on i_start_w. COUNT: accept one byte; N in 1..DEPTH -> DATA, else -> ERR.
- DATA: accept bytes into a 32-bit assembly register at lane [8*k+7:8*k], k = 0..3; after lane 3 -> WRITE.
- WRITE (one cycle): o_we_w=1, o_wdata_w = assembled word, o_waddr_w = current address; then address+1, word count-1; words remaining -> DATA, else -> CHECK (macro on) or DONE.
- CHECK: accept one byte; equal to 8-bit modulo-256 sum of all 4N payload bytes -> DONE, else -> ERR.
- DONE: o_done_w=1, o_cpu_rst_n_w=1. ERR: o_err_w=1, o_cpu_rst_n_w=0. i_start_w in either -> COUNT, clearing address, byte lane, checksum, and done/err.
- i_start_w in COUNT/DATA/WRITE/CHECK is ignored. i_byte_valid_w outside accepting states is ignored; no byte is consumed.
- Address never wraps: N ≤ DEPTH bounds the last write at DEPTH-1.

## Timing
- Reset values: state IDLE, o_byte_ready_w=0, o_we_w=0, o_waddr_w=0, o_wdata_w=0, o_cpu_rst_n_w=0, o_done_w=0, o_err_w=0; internal counters and checksum 0.
- o_byte_ready_w is a registered state decode: high in COUNT, DATA, CHECK; low in WRITE, so word k+1 lane 0 cannot be taken in the write cycle.
- Write latency: o_we_w rises the cycle after the 4th byte of a word is accepted.
- Full N=64 load with back-to-back valid: 1 + 64×5 + 1 cycles from COUNT entry to DONE entry (macro on).
- o_cpu_rst_n_w rises the cycle DONE is entered and falls the cycle DONE is left on a new i_start_w.
- Asynchronous reset mid-load returns to IDLE at once; partial IMEM contents are left as written.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: the checksum byte is part of the frame; CHECK state is present; a mismatch gives ERR.
- Undefined: no checksum byte and no CHECK state; the final WRITE goes directly to DONE, and the sum logic is removed.

## Structure
- Package imem_loader_pkg: state enum (IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR) and the DEPTH/ADDR_W defaults.
- Flat module; no sub-module. The byte-lane assembler is small enough to stay inline.

## Test plan
- Macro on, N=1, bytes 01, 20 08 00 05, checksum 0x2D -> one write addr 0 data 0x05000820; DONE; o_cpu_rst_n_w=1.
- Macro on, N=2, correct payload and checksum, with valid deasserted 3 cycles mid-word -> writes addr 0,1 with correct words; no byte lost or duplicated.
- Count byte 0x00, then separately 0x41 -> ERR, no o_we_w, o_cpu_rst_n_w stays 0.
- Macro on, N=64 back-to-back -> 64 writes addr 0..63, DONE exactly 322 cycles after COUNT entry, no address wrap.
- Macro on, N=1 with wrong checksum 0x00 -> word written, then ERR; new i_start_w with a valid frame -> DONE.
- i_rst_w low during DATA after 2 bytes -> all outputs at reset values immediately; new start with N=1 writes a fresh word to addr 0.
